// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, digit decode and the entry FSM encoding.
// The keypad scanner uses the same key code constants.
package keypad_pkg;

    localparam int MAX_DIGITS_DEF = 3;
    localparam int BIN_W_DEF      = 10;

    localparam logic [3:0] KEY_A     = 4'd3;
    localparam logic [3:0] KEY_ENTER = 4'd14;
    localparam logic [3:0] KEY_CLEAR = 4'd12;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        HOLD    = 2'd2
    } entry_state_t;

    typedef struct packed {
        logic       is_digit;
        logic [3:0] value;
    } digit_t;

    // Scanner code {row,col} to decimal digit; non-digit keys return is_digit=0.
    function automatic digit_t digit_lookup(input logic [3:0] code);
        digit_t d;
        d = '{is_digit: 1'b1, value: 4'd0};
        case (code)
            4'd0:    d.value = 4'd1;
            4'd1:    d.value = 4'd2;
            4'd2:    d.value = 4'd3;
            4'd4:    d.value = 4'd4;
            4'd5:    d.value = 4'd5;
            4'd6:    d.value = 4'd6;
            4'd8:    d.value = 4'd7;
            4'd9:    d.value = 4'd8;
            4'd10:   d.value = 4'd9;
            4'd13:   d.value = 4'd0;
            default: d.is_digit = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/keypad_entry_operand_acc.sv
// One decimal operand accumulator: BCD and binary images plus a digit count
// that saturates at MAX_DIGITS. Next-state values are exported for registered muxing.
module operand_acc
    import keypad_pkg::*;
#(
    parameter int MAX_DIGITS = MAX_DIGITS_DEF,
    parameter int BIN_W      = BIN_W_DEF,
    parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push_digit,
    input  logic [3:0]              digit,
    input  logic                    clear,
    output logic [4*MAX_DIGITS-1:0] bcd,
    output logic [BIN_W-1:0]        bin,
    output logic [CNT_W-1:0]        cnt,
    output logic [4*MAX_DIGITS-1:0] bcd_nxt,
    output logic [CNT_W-1:0]        cnt_nxt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

    logic [BIN_W-1:0] bin_nxt;

    always_comb begin
        bcd_nxt = bcd;
        bin_nxt = bin;
        cnt_nxt = cnt;
        if (clear) begin
            bcd_nxt = '0;
            bin_nxt = '0;
            cnt_nxt = '0;
        end else if (push_digit && (cnt < CNT_MAX)) begin
            bcd_nxt = {bcd[4*MAX_DIGITS-5:0], digit};
            // bin*10 + d without a multiplier
            bin_nxt = (bin << 3) + (bin << 1) + BIN_W'(digit);
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd <= '0;
            bin <= '0;
            cnt <= '0;
        end else begin
            bcd <= bcd_nxt;
            bin <= bin_nxt;
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// Operand-entry controller: decodes keypad events, builds operands A and B,
// and offers the pair downstream. ops_valid/ops_ready: the pair transfers on
// any edge where both are 1; while ops_valid=1 all operand outputs are held.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int MAX_DIGITS = MAX_DIGITS_DEF,
    parameter int BIN_W      = BIN_W_DEF,
    parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    key_pulse,
    input  logic [3:0]              key_code,
    output logic                    ops_valid,
    input  logic                    ops_ready,
    output logic [4*MAX_DIGITS-1:0] op_a_bcd,
    output logic [4*MAX_DIGITS-1:0] op_b_bcd,
    output logic [BIN_W-1:0]        op_a_bin,
    output logic [BIN_W-1:0]        op_b_bin,
    output logic [4*MAX_DIGITS-1:0] disp_bcd,
    output logic                    disp_sel,
    output logic [CNT_W-1:0]        digit_cnt,
    output logic [1:0]              fsm_state
);

    entry_state_t state, state_nxt;
    digit_t       dk;
    logic         push_a, push_b, clr;

    logic [4*MAX_DIGITS-1:0] a_bcd_nxt, b_bcd_nxt;
    logic [CNT_W-1:0]        a_cnt, b_cnt, a_cnt_nxt, b_cnt_nxt;

    always_comb begin
        dk        = digit_lookup(key_code);
        push_a    = 1'b0;
        push_b    = 1'b0;
        clr       = 1'b0;
        state_nxt = state;
        case (state)
            ENTER_A: if (key_pulse) begin
                if (dk.is_digit)              push_a = 1'b1;
                else if (key_code == KEY_A)   state_nxt = ENTER_B;
                else if (key_code == KEY_CLEAR) clr = 1'b1;
            end
            ENTER_B: if (key_pulse) begin
                if (dk.is_digit)                push_b = 1'b1;
                else if (key_code == KEY_ENTER) state_nxt = HOLD;
                else if (key_code == KEY_CLEAR) begin
                    clr       = 1'b1;
                    state_nxt = ENTER_A;
                end
            end
            // Keys are ignored here; only the handshake leaves HOLD.
            HOLD: if (ops_ready) begin
                clr       = 1'b1;
                state_nxt = ENTER_A;
            end
            default: state_nxt = ENTER_A;
        endcase
    end

    operand_acc #(.MAX_DIGITS(MAX_DIGITS), .BIN_W(BIN_W), .CNT_W(CNT_W)) u_acc_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_digit (push_a),
        .digit      (dk.value),
        .clear      (clr),
        .bcd        (op_a_bcd),
        .bin        (op_a_bin),
        .cnt        (a_cnt),
        .bcd_nxt    (a_bcd_nxt),
        .cnt_nxt    (a_cnt_nxt)
    );

    operand_acc #(.MAX_DIGITS(MAX_DIGITS), .BIN_W(BIN_W), .CNT_W(CNT_W)) u_acc_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_digit (push_b),
        .digit      (dk.value),
        .clear      (clr),
        .bcd        (op_b_bcd),
        .bin        (op_b_bin),
        .cnt        (b_cnt),
        .bcd_nxt    (b_bcd_nxt),
        .cnt_nxt    (b_cnt_nxt)
    );

    // Display mux is registered from next-state values so it tracks the operands with no extra lag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ENTER_A;
            ops_valid <= 1'b0;
            disp_bcd  <= '0;
            disp_sel  <= 1'b0;
            digit_cnt <= '0;
        end else begin
            state     <= state_nxt;
            ops_valid <= (state_nxt == HOLD);
            disp_sel  <= (state_nxt != ENTER_A);
            disp_bcd  <= (state_nxt == ENTER_A) ? a_bcd_nxt : b_bcd_nxt;
            digit_cnt <= (state_nxt == ENTER_A) ? a_cnt_nxt : b_cnt_nxt;
        end
    end

    assign fsm_state = state;

endmodule
